// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared state type and segment codes for the 2-digit scan display
//
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.

package seg7_pkg;

    typedef enum logic [1:0] {
        BLANK_U = 2'd0,
        SHOW_U  = 2'd1,
        BLANK_T = 2'd2,
        SHOW_T  = 2'd3
    } seg7_state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to 7-segment decoder, active-high
//
// Ports:
//   bcd  in  4  BCD digit; codes 10-15 decode to a dash
//   seg  out 7  segments {g,f,e,d,c,b,a}, 1 = lit

module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 2-digit multiplexed 7-segment driver with blanking gaps
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank the tens digit when it is 0).
//
// Ports:
//   clk         in   1  system clock
//   reset_n     in   1  asynchronous active-low reset
//   dv          in   4  units BCD digit
//   ch          in   4  tens BCD digit
//   seg         out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   an          out  2  digit enables {tens,units}, polarity per AN_ACTIVE_LOW
//   frame_tick  out  1  one-cycle pulse on the cycle dv/ch are captured

module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] dv,
    input  logic [3:0] ch,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    // XOR masks turn active-high internal values into pin polarity.
    localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    seg7_state_t   state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [3:0]    dv_snap_q, dv_snap_nxt;
    logic [3:0]    ch_snap_q, ch_snap_nxt;
    logic          tick_nxt;
    logic [3:0]    dec_in;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_act;
    logic [1:0]    an_act;

    bcd_to_seg7 u_dec (
        .bcd (dec_in),
        .seg (dec_seg)
    );

    // Counter counts down to zero; the state advances on the zero cycle and the
    // counter is reloaded for the state being entered.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q - CNT_ONE;
        dv_snap_nxt = dv_snap_q;
        ch_snap_nxt = ch_snap_q;
        tick_nxt    = 1'b0;
        if (cnt_q == '0) begin
            case (state_q)
                BLANK_U: begin
                    state_nxt   = SHOW_U;
                    dv_snap_nxt = dv;
                    ch_snap_nxt = ch;
                    tick_nxt    = 1'b1;
                end
                SHOW_U:  state_nxt = BLANK_T;
                BLANK_T: state_nxt = SHOW_T;
                default: state_nxt = BLANK_U;
            endcase
            cnt_nxt = (state_nxt == SHOW_U || state_nxt == SHOW_T) ? SHOW_LOAD : BLANK_LOAD;
        end
    end

    // Outputs are computed for the next state so they register on the same edge
    // as the state; the single decoder is steered to whichever digit will be lit.
    always_comb begin
        dec_in  = (state_nxt == SHOW_T) ? ch_snap_nxt : dv_snap_nxt;
        an_act  = 2'b00;
        seg_act = SEG_OFF;
        case (state_nxt)
            SHOW_U: begin
                an_act  = 2'b01;
                seg_act = dec_seg;
            end
            SHOW_T: begin
                an_act  = 2'b10;
                seg_act = dec_seg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (ch_snap_nxt == 4'd0) begin
                    seg_act = SEG_OFF;
                end
`endif
            end
            default: begin
                an_act  = 2'b00;
                seg_act = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= BLANK_U;
            cnt_q      <= BLANK_LOAD;
            dv_snap_q  <= 4'd0;
            ch_snap_q  <= 4'd0;
            seg        <= SEG_OFF ^ SEG_XOR;
            an         <= 2'b00 ^ AN_XOR;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            dv_snap_q  <= dv_snap_nxt;
            ch_snap_q  <= ch_snap_nxt;
            seg        <= seg_act ^ SEG_XOR;
            an         <= an_act ^ AN_XOR;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display

module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] dv;
    logic [3:0] ch;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    // Expected entries: {an[1:0], seg[6:0], frame_tick}, one per clock cycle.
    logic [9:0] sb[$];

    seg7_scan_display #(
        .REFRESH_DIV    (4),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dv         (dv),
        .ch         (ch),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            total++;
            if (an === 2'b00) begin
                bad++;
                $display("FAIL both_anodes_on an=%b required=not 00", an);
            end
        end
    end

    function automatic logic [6:0] code(input logic [3:0] d);
        case (d)
            4'd0: code = 7'h3F;
            4'd1: code = 7'h06;
            4'd2: code = 7'h5B;
            4'd3: code = 7'h4F;
            4'd4: code = 7'h66;
            4'd5: code = 7'h6D;
            4'd6: code = 7'h7D;
            4'd7: code = 7'h07;
            4'd8: code = 7'h7F;
            4'd9: code = 7'h6F;
            default: code = 7'h40;
        endcase
    endfunction

    task automatic push_blank(input int n);
        for (int i = 0; i < n; i++) sb.push_back({2'b11, 7'h7F, 1'b0});
    endtask

    // One 12-cycle frame starting at the frame_tick cycle: 4 units, 2 blank, 4 tens, 2 blank.
    task automatic push_frame(input logic [3:0] u, input logic [3:0] t);
        logic [6:0] tseg;
        tseg = ~code(t);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (t == 4'd0) tseg = 7'h7F;
`endif
        for (int i = 0; i < 4; i++) sb.push_back({2'b10, ~code(u), (i == 0)});
        push_blank(2);
        for (int i = 0; i < 4; i++) sb.push_back({2'b01, tseg, 1'b0});
        push_blank(2);
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (frame_tick !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_tick_timeout frame_tick=%b required=1 within 40 cycles", name, frame_tick);
        end
    endtask

    task automatic test_reset;
        logic [9:0] e;
        reset_n = 1'b0;
        dv = 4'd0;
        ch = 4'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({an, seg, frame_tick} !== {2'b11, 7'h7F, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold got an=%b seg=%h tick=%b required an=11 seg=7f tick=0",
                     an, seg, frame_tick);
        end
        sb.delete();
        reset_n = 1'b1;
        push_blank(1);
        push_frame(4'd0, 4'd0);
        push_blank(0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({an, seg, frame_tick} !== e) begin
                bad++;
                $display("FAIL reset_release got an=%b seg=%h tick=%b required an=%b seg=%h tick=%b",
                         an, seg, frame_tick, e[9:8], e[7:1], e[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_steady(input string name, input logic [3:0] u, input logic [3:0] t);
        logic [9:0] e;
        dv = u;
        ch = t;
        sb.delete();
        // Inputs may already have been captured at a tick in flight; skip to a clean frame.
        wait_tick(name);
        @(negedge clk);
        wait_tick(name);
        push_frame(u, t);
        sb.push_back({2'b10, ~code(u), 1'b1});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({an, seg, frame_tick} !== e) begin
                bad++;
                $display("FAIL %s got an=%b seg=%h tick=%b required an=%b seg=%h tick=%b",
                         name, an, seg, frame_tick, e[9:8], e[7:1], e[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tearing;
        logic [9:0] e;
        int i;
        dv = 4'd9;
        ch = 4'd4;
        sb.delete();
        wait_tick("tearing");
        @(negedge clk);
        wait_tick("tearing");
        push_frame(4'd9, 4'd4);
        push_frame(4'd0, 4'd5);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({an, seg, frame_tick} !== e) begin
                bad++;
                $display("FAIL tearing[%0d] got an=%b seg=%h tick=%b required an=%b seg=%h tick=%b",
                         i, an, seg, frame_tick, e[9:8], e[7:1], e[0]);
            end
            if (i == 1) begin
                dv = 4'd0;
                ch = 4'd5;
            end
            i++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_show_t;
        logic [9:0] e;
        int n;
        n = 0;
        while (an !== 2'b01 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (an !== 2'b01) begin
            bad++;
            $display("FAIL show_t_timeout an=%b required=01 within 40 cycles", an);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({an, seg, frame_tick} !== {2'b11, 7'h7F, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got an=%b seg=%h tick=%b required an=11 seg=7f tick=0",
                     an, seg, frame_tick);
        end
        dv = 4'd8;
        ch = 4'd2;
        @(negedge clk);
        sb.delete();
        reset_n = 1'b1;
        push_blank(1);
        push_frame(4'd8, 4'd2);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({an, seg, frame_tick} !== e) begin
                bad++;
                $display("FAIL reset_recover got an=%b seg=%h tick=%b required an=%b seg=%h tick=%b",
                         an, seg, frame_tick, e[9:8], e[7:1], e[0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_steady("steady_5_3", 4'd5, 4'd3);
        test_tearing();
        test_steady("invalid_dv12", 4'd12, 4'd1);
        test_steady("invalid_dv15", 4'd15, 4'd9);
        test_steady("leading_zero", 4'd7, 4'd0);
        test_steady("back_to_back", 4'd2, 4'd6);
        test_reset_mid_show_t();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
